letreiro_scroll_matrix: RTL and testbench

//  Parametrised scrolling marquee driver for a ROWS x COLS LED matrix.
//  - Holds a writable message of MSG_LEN columns.
//  - Row-scans the matrix and scrolls the visible COLS-wide window left or right.
//  - Can also pause or blink the display.
//  - Replaces the fixed 5x7 shift-register marquee; sits between the board switches/loader and the matrix pins.

---
 rtl/letreiro_pkg.sv | 15 +
 rtl/letreiro_tick_gen.sv | 33 +++
 rtl/letreiro_scroll_matrix.sv | 161 ++++++++++++++++
 tb/tb_letreiro_scroll_matrix.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/letreiro_pkg.sv
// Shared definitions for the scrolling marquee: mode encodings and default geometry.
package letreiro_pkg;

  typedef enum logic [1:0] {
    MODE_PAUSE = 2'b00,
    MODE_LEFT  = 2'b01,
    MODE_RIGHT = 2'b10,
    MODE_BLINK = 2'b11
  } mode_e;

  localparam int unsigned DEF_ROWS    = 5;
  localparam int unsigned DEF_COLS    = 7;
  localparam int unsigned DEF_MSG_LEN = 32;

endpackage

// File: rtl/letreiro_tick_gen.sv
// Modulo-DIV counter advanced by en; tick is high on the enabled terminal-count cycle.
module letreiro_tick_gen #(
  parameter int unsigned DIV = 2
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic en,
  output logic tick
);

  localparam int unsigned CW     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned LAST_I = DIV - 1;
  localparam logic [CW-1:0] LAST = LAST_I[CW-1:0];

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = en && (cnt_q == LAST);
    cnt_d = cnt_q;
    if (en) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/letreiro_scroll_matrix.sv
// Row-scanned ROWS x COLS marquee with a writable MSG_LEN-column message,
// scrolling left/right, pause and blink.
module letreiro_scroll_matrix
  import letreiro_pkg::*;
#(
  parameter int unsigned ROWS        = DEF_ROWS,
  parameter int unsigned COLS        = DEF_COLS,
  parameter int unsigned MSG_LEN     = DEF_MSG_LEN,
  parameter int unsigned SCAN_DIV    = 1000,
  parameter int unsigned STEP_FRAMES = 20
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic [1:0]                 mode,
  input  logic                       wr_en,
  input  logic [$clog2(MSG_LEN)-1:0] wr_addr,
  input  logic [ROWS-1:0]            wr_data,
  output logic [ROWS-1:0]            row_sel,
  output logic [COLS-1:0]            col_data,
  output logic                       frame_start,
  output logic                       step
);

  localparam int unsigned AW      = $clog2(MSG_LEN);
  localparam int unsigned RW      = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned ROWS_M1 = ROWS - 1;
  localparam int unsigned LEN_M1  = MSG_LEN - 1;

  localparam logic [RW-1:0] ROW_LAST  = ROWS_M1[RW-1:0];
  localparam logic [AW:0]   MSG_LEN_W = MSG_LEN[AW:0];
  localparam logic [AW:0]   ONE_W     = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] LAST_OFF  = LEN_M1[AW-1:0];

  mode_e mode_s;
  assign mode_s = mode_e'(mode);

  logic scan_tick, frame_wrap, step_due;

  logic [ROWS-1:0] mem_q [MSG_LEN];
  logic [ROWS-1:0] mem_d [MSG_LEN];

  logic [RW-1:0]   row_q, row_d;
  logic [AW-1:0]   offset_q, offset_d;
  logic            blank_q, blank_d;
  logic            step_pend_q, step_pend_d;
  logic [ROWS-1:0] row_sel_q, row_sel_d;
  logic [COLS-1:0] col_data_q, col_data_d;
  logic            frame_start_q, frame_start_d;
  logic            step_q, step_d;

  logic [AW:0] inc_w;
  logic [AW:0] idx;

  assign frame_wrap = scan_tick && (row_q == ROW_LAST);

  letreiro_tick_gen #(.DIV(SCAN_DIV)) u_scan_div (
    .CLK   (CLK),
    .RST_N (RST_N),
    .en    (1'b1),
    .tick  (scan_tick)
  );

  letreiro_tick_gen #(.DIV(STEP_FRAMES)) u_step_div (
    .CLK   (CLK),
    .RST_N (RST_N),
    .en    (frame_wrap),
    .tick  (step_due)
  );

  always_comb begin
    mem_d = mem_q;
    if (wr_en && ({1'b0, wr_addr} < MSG_LEN_W)) begin
      mem_d[wr_addr] = wr_data;
    end
  end

  always_comb begin
    row_d         = row_q;
    offset_d      = offset_q;
    blank_d       = blank_q;
    step_pend_d   = step_pend_q;
    row_sel_d     = row_sel_q;
    col_data_d    = col_data_q;
    frame_start_d = 1'b0;
    step_d        = 1'b0;
    inc_w         = {1'b0, offset_q} + ONE_W;
    idx           = '0;

    // The frame count completes on the last row; the step itself is deferred
    // to the following row-0 tick so that whole frame uses the new offset.
    if (step_due) begin
      step_pend_d = 1'b1;
    end

    if (scan_tick) begin
      row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;

      if (step_pend_q && (row_q == '0)) begin
        step_pend_d = 1'b0;
        step_d      = 1'b1;
        case (mode_s)
          MODE_PAUSE: offset_d = offset_q;
          MODE_LEFT:  offset_d = (inc_w == MSG_LEN_W) ? '0 : inc_w[AW-1:0];
          MODE_RIGHT: offset_d = (offset_q == '0) ? LAST_OFF : offset_q - 1'b1;
          MODE_BLINK: offset_d = offset_q;
        endcase
        blank_d = (mode_s == MODE_BLINK) ? ~blank_q : 1'b0;
      end

      row_sel_d         = '0;
      row_sel_d[row_q]  = 1'b1;
      frame_start_d     = (row_q == '0);

      for (int unsigned c = 0; c < COLS; c++) begin
        idx = {1'b0, offset_d} + c[AW:0];
        if (idx >= MSG_LEN_W) begin
          idx = idx - MSG_LEN_W;
        end
        col_data_d[c] = blank_d ? 1'b0 : mem_q[idx[AW-1:0]][row_q];
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int unsigned i = 0; i < MSG_LEN; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      row_q         <= '0;
      offset_q      <= '0;
      blank_q       <= 1'b0;
      step_pend_q   <= 1'b0;
      row_sel_q     <= '0;
      col_data_q    <= '0;
      frame_start_q <= 1'b0;
      step_q        <= 1'b0;
    end else begin
      row_q         <= row_d;
      offset_q      <= offset_d;
      blank_q       <= blank_d;
      step_pend_q   <= step_pend_d;
      row_sel_q     <= row_sel_d;
      col_data_q    <= col_data_d;
      frame_start_q <= frame_start_d;
      step_q        <= step_d;
    end
  end

  assign row_sel     = row_sel_q;
  assign col_data    = col_data_q;
  assign frame_start = frame_start_q;
  assign step        = step_q;

endmodule

// File: tb/tb_letreiro_scroll_matrix.sv
// Directed and randomized bench for letreiro_scroll_matrix with a cycle-count reference model.
module tb_letreiro_scroll_matrix;

  localparam int unsigned ROWS        = 5;
  localparam int unsigned COLS        = 7;
  localparam int unsigned MSG_LEN     = 10;
  localparam int unsigned SCAN_DIV    = 4;
  localparam int unsigned STEP_FRAMES = 2;
  localparam int unsigned AW          = $clog2(MSG_LEN);

  logic            CLK = 1'b0;
  logic            RST_N = 1'b0;
  logic [1:0]      mode = 2'b00;
  logic            wr_en = 1'b0;
  logic [AW-1:0]   wr_addr = '0;
  logic [ROWS-1:0] wr_data = '0;
  logic [ROWS-1:0] row_sel;
  logic [COLS-1:0] col_data;
  logic            frame_start;
  logic            step;

  letreiro_scroll_matrix #(
    .ROWS        (ROWS),
    .COLS        (COLS),
    .MSG_LEN     (MSG_LEN),
    .SCAN_DIV    (SCAN_DIV),
    .STEP_FRAMES (STEP_FRAMES)
  ) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .mode        (mode),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .row_sel     (row_sel),
    .col_data    (col_data),
    .frame_start (frame_start),
    .step        (step)
  );

  always #5 CLK = ~CLK;

  int passed = 0;
  int total  = 0;

  // Reference model: timing derived purely from edges counted since reset release.
  int unsigned     n_edges;
  int unsigned     off_m;
  bit              blank_m;
  logic [ROWS-1:0] mem_m [MSG_LEN];
  logic [ROWS-1:0] exp_row_sel;
  logic [COLS-1:0] exp_col;
  logic            exp_fs, exp_step;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    n_edges = 0;
    off_m   = 0;
    blank_m = 1'b0;
    for (int i = 0; i < MSG_LEN; i++) mem_m[i] = '0;
    exp_row_sel = '0;
    exp_col     = '0;
    exp_fs      = 1'b0;
    exp_step    = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_row_sel"}, row_sel, 0);
    check({tag, "_col_data"}, col_data, 0);
    check({tag, "_frame_start"}, frame_start, 0);
    check({tag, "_step"}, step, 0);
  endtask

  task automatic clk_check();
    int unsigned k, row, f;
    @(posedge CLK);
    n_edges++;
    exp_fs   = 1'b0;
    exp_step = 1'b0;
    if (n_edges % SCAN_DIV == 0) begin
      k   = n_edges / SCAN_DIV;
      row = (k - 1) % ROWS;
      f   = (k - 1) / ROWS;
      if (row == 0 && f != 0 && f % STEP_FRAMES == 0) begin
        exp_step = 1'b1;
        case (mode)
          2'b01:   off_m = (off_m + 1) % MSG_LEN;
          2'b10:   off_m = (off_m + MSG_LEN - 1) % MSG_LEN;
          default: ;
        endcase
        blank_m = (mode == 2'b11) ? !blank_m : 1'b0;
      end
      exp_row_sel      = '0;
      exp_row_sel[row] = 1'b1;
      exp_fs           = (row == 0);
      for (int c = 0; c < COLS; c++)
        exp_col[c] = blank_m ? 1'b0 : mem_m[(off_m + c) % MSG_LEN][row];
    end
    if (wr_en && wr_addr < MSG_LEN) mem_m[wr_addr] = wr_data;
    #1;
    check("row_sel", row_sel, exp_row_sel);
    check("col_data", col_data, exp_col);
    check("frame_start", frame_start, exp_fs);
    check("step", step, exp_step);
  endtask

  task automatic run_to_step(output int unsigned cycles);
    cycles = 0;
    do begin
      clk_check();
      cycles++;
    end while (step !== 1'b1 && cycles < 200);
    check("step_seen", step, 1);
  endtask

  task automatic load_pattern();
    for (int k = 0; k < MSG_LEN; k++) begin
      wr_en      = 1'b1;
      wr_addr    = AW'(k);
      wr_data    = '0;
      wr_data[k % ROWS] = 1'b1;
      clk_check();
    end
    wr_en = 1'b0;
  endtask

  initial begin
    int unsigned cyc;
    int unsigned guard;

    model_reset();
    repeat (3) @(posedge CLK);
    #1;
    check_all_zero("reset");
    @(negedge CLK);
    RST_N = 1'b1;

    // Reset while row 3 is being driven
    load_pattern();
    guard = 0;
    do begin
      clk_check();
      guard++;
    end while (exp_row_sel != 5'b01000 && guard < 100);
    check("row3_driven", row_sel, 5'b01000);
    #2;
    RST_N = 1'b0;
    #1;
    check_all_zero("midscan_reset");
    model_reset();
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (3) clk_check();
    check("pre_first_row", row_sel, 0);
    clk_check();
    check("first_row_sel", row_sel, 5'b00001);
    check("first_col_data", col_data, 0);
    check("first_frame_start", frame_start, 1);

    // Pause
    load_pattern();
    mode = 2'b00;
    run_to_step(cyc);
    check("pause_row0", col_data, 7'b0100001);
    run_to_step(cyc);
    check("step_period", cyc, 40);
    check("pause_row0_again", col_data, 7'b0100001);

    // Scroll left, full lap including 9 -> 0
    mode = 2'b01;
    run_to_step(cyc);
    check("left_first", col_data, 7'b0010000);
    repeat (9) run_to_step(cyc);
    check("left_lap", col_data, 7'b0100001);

    // Scroll right from offset 0
    mode = 2'b10;
    run_to_step(cyc);
    check("right_wrap", col_data, 7'b1000010);

    // Blink, then leave blink while blanked
    mode = 2'b11;
    run_to_step(cyc);
    check("blink_off", col_data, 0);
    run_to_step(cyc);
    check("blink_on", col_data, 7'b1000010);
    run_to_step(cyc);
    check("blink_off2", col_data, 0);
    mode = 2'b01;
    repeat (20) clk_check();
    check("still_blank", col_data, 0);
    run_to_step(cyc);
    check("left_unblank", col_data, 7'b0100001);

    // Write colliding with the scan tick that reads row 1
    mode  = 2'b00;
    guard = 0;
    while (!(((n_edges + 1) % SCAN_DIV == 0) &&
             ((((n_edges + 1) / SCAN_DIV) - 1) % ROWS == 1)) && guard < 100) begin
      clk_check();
      guard++;
    end
    wr_en   = 1'b1;
    wr_addr = AW'(3);
    wr_data = 5'b11111;
    clk_check();
    wr_en = 1'b0;
    check("collide_row", row_sel, 5'b00010);
    check("collide_old", col_data[3], 0);
    repeat (ROWS * SCAN_DIV) clk_check();
    check("collide_row_next", row_sel, 5'b00010);
    check("collide_new", col_data[3], 1);

    // Out-of-range address must be ignored
    wr_en   = 1'b1;
    wr_addr = AW'(12);
    wr_data = 5'b11111;
    clk_check();
    wr_en = 1'b0;
    repeat (2 * ROWS * SCAN_DIV) clk_check();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 59) == 0) mode = 2'($urandom);
      wr_en   = ($urandom_range(0, 3) == 0);
      wr_addr = AW'($urandom_range(0, 15));
      wr_data = ROWS'($urandom);
      clk_check();
    end
    wr_en = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
